// File: rtl/evt_kernel_sequencer.sv
// Event-driven kernel sweep sequencer: each accepted event triggers a row-major sweep over an 8x8 grid.
// Optional macro EVT_SEQ_SKIP_BORDER_EN restricts the sweep to the inner 6x6 (coordinates 1..6).
module evt_kernel_sequencer #(
    parameter int SEQ_ADDR_WIDTH  = 8,
    parameter int NEURON_ID_WIDTH = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clk_en_i,
    input  logic                       clear_i,
    input  logic                       evt_valid_i,
    output logic                       evt_ready_o,
    input  logic [NEURON_ID_WIDTH-1:0] evt_addr_i,
    output logic                       seq_valid_o,
    input  logic                       seq_ready_i,
    output logic [SEQ_ADDR_WIDTH-1:0]  sequencer_addr_o,
    output logic [NEURON_ID_WIDTH-1:0] neuron_addr_o,
    output logic                       seq_last_o,
    output logic                       busy_o,
    output logic [CNT_WIDTH-1:0]       evt_count_o
);

    localparam int HALF = SEQ_ADDR_WIDTH / 2;

`ifdef EVT_SEQ_SKIP_BORDER_EN
    localparam logic [2:0] COORD_START = 3'd1;
    localparam logic [2:0] COORD_END   = 3'd6;
`else
    localparam logic [2:0] COORD_START = 3'd0;
    localparam logic [2:0] COORD_END   = 3'd7;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [2:0]                   x_q, x_d;
    logic [2:0]                   y_q, y_d;
    logic                         last_q, last_d;
    logic [NEURON_ID_WIDTH-1:0]   naddr_q, naddr_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic                         accept_s;
    logic                         beat_done_s;
    logic [SEQ_ADDR_WIDTH-1:0]    seq_addr_s;

    // Handshake decode shared by ready output and next-state logic
    always_comb begin
        beat_done_s = (state_q == SWEEP) && seq_ready_i;
        evt_ready_o = clk_en_i && !clear_i &&
                      ((state_q == IDLE) || (beat_done_s && last_q));
        accept_s    = evt_valid_i && evt_ready_o;
        seq_valid_o = clk_en_i && (state_q == SWEEP);
        busy_o      = (state_q == SWEEP);
    end

    // Next-state, coordinate advance, event latch and saturating counter
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        naddr_d = naddr_q;
        cnt_d   = cnt_q;
        if (!clk_en_i) begin
            state_d = state_q;
        end else if (clear_i) begin
            state_d = IDLE;
            x_d     = 3'd0;
            y_d     = 3'd0;
            cnt_d   = '0;
        end else begin
            if (beat_done_s && last_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            if (accept_s) begin
                state_d = SWEEP;
                naddr_d = evt_addr_i;
                x_d     = COORD_START;
                y_d     = COORD_START;
            end else if (beat_done_s) begin
                // Final beat with no follow-on event: park on the last coordinate
                if (last_q) begin
                    state_d = IDLE;
                end else if (x_q == COORD_END) begin
                    x_d = COORD_START;
                    y_d = y_q + 3'd1;
                end else begin
                    x_d = x_q + 3'd1;
                end
            end else begin
                state_d = state_q;
            end
        end
        last_d = (x_d == COORD_END) && (y_d == COORD_END);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            last_q  <= 1'b0;
            naddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            naddr_q <= naddr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pack coordinates into the halves of the sequencer address, upper bits zero
    always_comb begin
        seq_addr_s              = '0;
        seq_addr_s[2:0]         = x_q;
        seq_addr_s[HALF +: 3]   = y_q;
    end

    assign sequencer_addr_o = seq_addr_s;
    assign neuron_addr_o    = naddr_q;
    assign seq_last_o       = last_q;
    assign evt_count_o      = cnt_q;

endmodule
